// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the time-multiplexed 8x8 multiplier: FSM encoding,
// product width and carry-save helpers used by the Wallace tree.
package mult_share_arbiter_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] x,
                                                input logic [PROD_W-1:0] y,
                                                input logic [PROD_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  // Majority carries move up one column; bits beyond the product width are dropped.
  function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] x,
                                                  input logic [PROD_W-1:0] y,
                                                  input logic [PROD_W-1:0] z);
    logic [PROD_W-1:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[PROD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// Unsigned 8x8 multiplier: partial products reduced by a carry-save (Wallace)
// tree, final sum/carry pair resolved by a generate/propagate adder.
module wallace_mult_CLA_8
  import mult_share_arbiter_pkg::*;
(
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] pp_s [8];
  logic [PROD_W-1:0] s0_s, c0_s, s1_s, c1_s, s2_s, c2_s, s3_s, c3_s;
  logic [PROD_W-1:0] s4_s, c4_s, s5_s, c5_s;
  logic [PROD_W-1:0] prop_s, cy_s;

  // Partial-product rows, each already shifted into its column.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp_s[i] = {8'd0, (a & {8{b[i]}})} << i;
    end
  end

  assign s0_s = csa_sum  (pp_s[0], pp_s[1], pp_s[2]);
  assign c0_s = csa_carry(pp_s[0], pp_s[1], pp_s[2]);
  assign s1_s = csa_sum  (pp_s[3], pp_s[4], pp_s[5]);
  assign c1_s = csa_carry(pp_s[3], pp_s[4], pp_s[5]);
  assign s2_s = csa_sum  (s0_s, c0_s, s1_s);
  assign c2_s = csa_carry(s0_s, c0_s, s1_s);
  assign s3_s = csa_sum  (c1_s, pp_s[6], pp_s[7]);
  assign c3_s = csa_carry(c1_s, pp_s[6], pp_s[7]);
  assign s4_s = csa_sum  (s2_s, c2_s, s3_s);
  assign c4_s = csa_carry(s2_s, c2_s, s3_s);
  assign s5_s = csa_sum  (s4_s, c4_s, c3_s);
  assign c5_s = csa_carry(s4_s, c4_s, c3_s);

  // Final two-operand add; the carry recurrence flattens into lookahead logic.
  always_comb begin
    prop_s   = s5_s ^ c5_s;
    cy_s     = {PROD_W{1'b0}};
    for (int i = 0; i < PROD_W - 1; i++) begin
      cy_s[i+1] = (s5_s[i] & c5_s[i]) | (prop_s[i] & cy_s[i]);
    end
    p = prop_s ^ cy_s;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier among NREQ requesters;
// one operation in flight, result held until the consumer accepts it.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [PROD_W-1:0]   rsp_product,
  input  logic                rsp_ready,
  output logic                busy,
  output logic [15:0]         done_count
);

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_e            state_r, state_nx_s;
  logic [IDW-1:0]    last_grant_r, grant_id_s, id_r;
  logic [7:0]        a_r, b_r;
  logic              grant_s;
  logic [PROD_W-1:0] mult_s;

  function automatic logic [IDW-1:0] rr_slot(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % NREQ);
  endfunction

  // Round-robin pick: walking k downward lets the nearest slot after last_grant win.
  always_comb begin
    grant_id_s = last_grant_r;
    for (int k = NREQ; k >= 1; k--) begin
      grant_id_s = req_valid[rr_slot(last_grant_r, k)] ? rr_slot(last_grant_r, k) : grant_id_s;
    end
  end

  // Next-state and grant strobe; a grant is only possible from IDLE outside reset.
  always_comb begin
    state_nx_s = state_r;
    grant_s    = 1'b0;
    req_ready  = {NREQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (!rst && (|req_valid)) begin
          grant_s    = 1'b1;
          req_ready  = ONE_HOT0 << grant_id_s;
          state_nx_s = ST_CALC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CALC: state_nx_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, operand capture, result register and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IDW'(NREQ - 1);
      a_r          <= 8'd0;
      b_r          <= 8'd0;
      id_r         <= {IDW{1'b0}};
      rsp_valid    <= 1'b0;
      rsp_product  <= {PROD_W{1'b0}};
      rsp_id       <= {IDW{1'b0}};
      busy         <= 1'b0;
      done_count   <= 16'd0;
    end else begin
      state_r   <= state_nx_s;
      busy      <= (state_nx_s != ST_IDLE);
      rsp_valid <= (state_nx_s == ST_RESP);
      if (grant_s) begin
        a_r          <= req_a[8*int'(grant_id_s) +: 8];
        b_r          <= req_b[8*int'(grant_id_s) +: 8];
        id_r         <= grant_id_s;
        last_grant_r <= grant_id_s;
      end
      // Result fields only change when a new product lands, so they persist in IDLE.
      if (state_r == ST_CALC) begin
        rsp_product <= mult_s;
        rsp_id      <= id_r;
      end
      if ((state_r == ST_RESP) && rsp_ready) begin
        done_count <= done_count + 16'd1;
      end
    end
  end

  wallace_mult_CLA_8 u_mult (
    .a (a_r),
    .b (b_r),
    .p (mult_s)
  );

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter IDW, default 2: requester-id width, equal to ceil(log2(NREQ)).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NREQ: bit i is requester i's operand-valid signal.
REQ-007 SHALL have port req_a, input, 8*NREQ: requester i's multiplicand is bits [8i+7:8i].
REQ-008 SHALL have port req_b, input, 8*NREQ: requester i's multiplier is bits [8i+7:8i].
REQ-009 SHALL have port req_ready, output, NREQ: one-hot grant/accept strobe.
REQ-010 SHALL have port rsp_valid, output, 1: result is valid.
REQ-011 SHALL have port rsp_id, output, IDW: index of the requester that owns the result.
REQ-012 SHALL have port rsp_product, output, 16: unsigned product A*B.
REQ-013 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port done_count, output, 16: count of completed results.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, CALC, RESP.
REQ-017 In IDLE with any req_valid bit set, SHALL grant exactly one requester using round-robin, searching upward from last_grant+1 and wrapping modulo NREQ.
REQ-018 On a grant, SHALL assert req_ready for the granted requester for exactly that one cycle.
REQ-019 On a grant, SHALL latch that requester's A, B and id into registers and move to CALC.
REQ-020 req_ready SHALL be zero in every cycle except a grant cycle.
REQ-021 Requesters may deassert req_valid at any time before being granted; SHALL only grant a requester whose req_valid is high in the grant cycle.
REQ-022 In CALC, SHALL feed the latched operands to the shared multiplier and register the 16-bit product into rsp_product; the FSM SHALL move to RESP.
REQ-023 In RESP, SHALL hold rsp_valid high, with rsp_product and rsp_id stable, until rsp_ready is high.
REQ-024 On the cycle rsp_valid and rsp_ready are both high, SHALL return to IDLE and increment done_count.
REQ-025 done_count SHALL wrap from 0xFFFF to 0x0000.
REQ-026 Latency: the grant occurs in cycle N, rsp_valid rises at cycle N+2, and the earliest next grant is N+3 if rsp_ready is high at N+2.
REQ-027 Throughput SHALL be at most one product every 3 cycles.
REQ-028 SHALL never accept a new grant in CALC or RESP, so at most one operation is in flight.
REQ-029 last_grant SHALL update only on a grant; requesters with no pending request do not affect rotation.
REQ-030 A single requester holding req_valid continuously SHALL be granted on every IDLE visit.
REQ-031 The product SHALL be exact for all 65536 operand pairs: 0xFF*0xFF = 0xFE01, 0*x = 0.
REQ-032 rsp_product and rsp_id SHALL retain their last values in IDLE; rsp_valid SHALL be the only qualifier.

Reset
REQ-033 While rst is high at a clock edge: state=IDLE, req_ready=0, rsp_valid=0, rsp_product=0, rsp_id=0, busy=0, done_count=0, and last_grant=NREQ-1 so that requester 0 has first priority.
REQ-034 Reset in CALC or RESP SHALL abort the operation: no rsp_valid and no done_count increment, and the result is lost.
REQ-035 On the first cycle after reset deasserts, SHALL be able to grant.

Structure
REQ-036 SHALL define the FSM state encoding (2-bit IDLE/CALC/RESP) and the product width constant (16) in the shared multiplier package.
REQ-037 SHALL instantiate exactly one wallace_mult_CLA_8 as a sub-module, driven only from the latched operand registers.
REQ-038 The round-robin arbiter SHALL remain inline, not a separate module.

Verification
REQ-039 Single requester: after reset, req_valid=0001, A0=0xFF, B0=0xFF → req_ready=0001 at cycle 1, rsp_valid at cycle 3 with rsp_product=0xFE01, rsp_id=0, done_count=1.
REQ-040 All four requesters valid and rsp_ready tied high → grant order 0,1,2,3,0 with grants 3 cycles apart, and each rsp_id matches its grant.
REQ-041 Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_product and rsp_id stay stable, no req_ready pulses, and done_count increments once only after rsp_ready=1.
REQ-042 Reset mid-CALC (A=7, B=9) → no rsp_valid, done_count=0, and the next grant goes to requester 0.
REQ-043 Exhaustive sweep of all A,B through requester 2 → every rsp_product equals A*B, with rsp_id=2.
REQ-044 Force done_count to 0xFFFF and complete one operation → done_count=0x0000.
